qsys_sysid_check_ctrl: RTL and testbench
========================================

QSYS_SYSID_CHECK_CTRL -- requirements
Module: qsys_sysid_check_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- EXPECTED_ID, 32'd0, system ID word expected at sysid address 0.
- EXPECTED_TS, 32'd1496327636, timestamp word expected at sysid address 1.
- TIMEOUT_CYCLES, 16'd255, maximum waitrequest cycles per read (legal range 1..65535).

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle check request.
- avm_address, out, 1, sysid word select.
- avm_read, out, 1, Avalon-MM read strobe.
- avm_readdata, in, 32, sysid read data.
- avm_waitrequest, in, 1, slave stall.
- busy, out, 1, check sequence in progress.
- done, out, 1, one-cycle completion pulse.
- id_ok, out, 1, last ID compare matched.
- ts_ok, out, 1, last timestamp compare matched.
- timeout_err, out, 1, last sequence aborted on timeout.
- id_value, out, 32, last captured ID word.
- ts_value, out, 32, last captured timestamp word.

Function
REQ-003 The FSM SHALL have the states IDLE, RD_ID, RD_TS and FIN, and SHALL be in IDLE after reset.
REQ-004 In IDLE, start=1 SHALL move the FSM to RD_ID on the next cycle, and SHALL clear id_ok, ts_ok and timeout_err at that same edge. start SHALL be ignored in every other state.
REQ-005 In RD_ID the block SHALL drive avm_read=1 and avm_address=0. avm_address and avm_read SHALL remain stable while avm_waitrequest=1.
REQ-006 A read SHALL complete on the first cycle with avm_read=1 and avm_waitrequest=0. In that cycle avm_readdata SHALL be captured into id_value or ts_value.
REQ-007 Completion of the RD_ID read SHALL set id_ok=(avm_readdata==EXPECTED_ID) and SHALL go to RD_TS. RD_TS SHALL drive avm_address=1.
REQ-008 Completion of the RD_TS read SHALL set ts_ok=(avm_readdata==EXPECTED_TS) and SHALL go to FIN.
REQ-009 FIN SHALL assert done for exactly one cycle and SHALL return to IDLE.
REQ-010 Back-to-back sequence latency with avm_waitrequest=0 SHALL be: start at cycle N, ID read at N+1, timestamp read at N+2, done at N+3.
REQ-011 A 16-bit wait counter SHALL be cleared on entry to each read state and SHALL increment on every cycle with avm_waitrequest=1.
- If the counter reaches TIMEOUT_CYCLES while avm_waitrequest=1, the block SHALL drop avm_read, set timeout_err=1 and go to FIN.
- A read that completes in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as a completed read, not a timeout.
REQ-012 On a timeout, the ok flag of the aborted read and of any later read SHALL remain 0. The corresponding *_value register SHALL keep its previous contents.
REQ-013 busy SHALL be 1 in RD_ID, RD_TS and FIN, and 0 in IDLE.
REQ-014 avm_read SHALL be 0 in IDLE and FIN. avm_address SHALL be 0 in IDLE and FIN.

Reset
REQ-015 reset=1 SHALL force the following at the next edge, from any state including mid-read:
- state to IDLE;
- avm_read, avm_address, busy, done, id_ok, ts_ok and timeout_err to 0;
- id_value and ts_value to 32'd0;
- the wait counter and retry counter to 0.
REQ-016 reset SHALL take priority over start, and a start in the same cycle as reset SHALL be dropped.

Configuration
REQ-017 With SYSID_CHECK_RETRY_EN defined, a FIN reached with (id_ok=0 or ts_ok=0) and timeout_err=0 SHALL restart the sequence at RD_ID instead of pulsing done.
- Restarts SHALL be counted by a 2-bit retry counter, up to 3 retries.
- done SHALL pulse only on a full match or after the third retry.
- busy SHALL stay 1 across retries.
- The retry counter SHALL clear on start.
REQ-018 Without SYSID_CHECK_RETRY_EN, the block SHALL perform exactly one pass per start, and no retry counter SHALL be present.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Slave returns 0 at address 0 and 1496327636 at address 1, waitrequest=0, start at cycle 10 -> done at cycle 13, id_ok=1, ts_ok=1, timeout_err=0.
- Slave returns 0x12345678 at address 1 -> ts_ok=0, ts_value=0x12345678, id_ok=1. With the macro, done comes after 4 passes; without it, after 1 pass.
- waitrequest=1 for 5 cycles on each read -> done at start+13, address and read stable during the stalls, both ok flags 1.
- waitrequest stuck at 1, TIMEOUT_CYCLES=4 -> avm_read falls after 4 stall cycles, timeout_err=1, id_ok=0, ts_ok=0, done pulses once.
- reset asserted during RD_TS stall -> next cycle: IDLE, busy=0, avm_read=0, all flags and values 0. A following start completes normally.
- start pulsed while busy -> ignored, and exactly one done pulse results.

Source files
------------

// File: rtl/qsys_sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// qsys_sysid_check_ctrl
//
// Reads the two words of a Qsys/Platform Designer sysid peripheral over an
// Avalon-MM master port (address 0 = system ID, address 1 = timestamp) and
// compares them against the values this build expects. Each read is guarded by
// a waitrequest timeout so a dead slave cannot hang the sequence.
//
// Build option:
//   SYSID_CHECK_RETRY_EN - when defined, a completed pass with a mismatch (and
//                          no timeout) restarts the reads, up to 3 retries,
//                          before done is pulsed.
//
// Parameters:
//   EXPECTED_ID    - system ID word expected at address 0
//   EXPECTED_TS    - timestamp word expected at address 1
//   TIMEOUT_CYCLES - max waitrequest cycles per read (1..65535)
//
// Ports:
//   clock, reset    - rising-edge clock, synchronous active-high reset
//   start           - one-cycle request, honoured only when idle
//   avm_*           - Avalon-MM read master (address, read, readdata, waitrequest)
//   busy            - sequence in progress (read states and FIN)
//   done            - one-cycle completion pulse
//   id_ok, ts_ok    - result of the last ID / timestamp compare
//   timeout_err     - last sequence aborted on a waitrequest timeout
//   id_value        - last captured ID word
//   ts_value        - last captured timestamp word
// -----------------------------------------------------------------------------
module qsys_sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1496327636,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        in_read;
  logic        rd_done;
  logic        rd_timeout;
  logic        retry;

  assign in_read = (state == RD_ID) || (state == RD_TS);
  // A read completes on any read-state cycle without waitrequest, so a
  // completion can never be mistaken for a timeout on the same cycle.
  assign rd_done = in_read && !avm_waitrequest;
  // wait_cnt holds the stalls seen so far; this stall is the one that makes the
  // count reach TIMEOUT_CYCLES.
  assign rd_timeout = in_read && avm_waitrequest &&
                      (wait_cnt == (TIMEOUT_CYCLES - 16'd1));

`ifdef SYSID_CHECK_RETRY_EN
  logic [1:0] retry_cnt;

  assign retry = (state == FIN) && (!id_ok || !ts_ok) && !timeout_err &&
                 (retry_cnt != 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      retry_cnt <= 2'd0;
    end else if ((state == IDLE) && start) begin
      retry_cnt <= 2'd0;
    end else if (retry) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end
`else
  assign retry = 1'b0;
`endif

  // Next state and Moore outputs.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would infer a latch.
    state_nxt   = state;
    busy        = 1'b1;
    done        = 1'b0;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RD_ID;
      end
      RD_ID: begin
        avm_read = 1'b1;
        if (rd_done)         state_nxt = RD_TS;
        else if (rd_timeout) state_nxt = FIN;
      end
      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (rd_done || rd_timeout) state_nxt = FIN;
      end
      FIN: begin
        if (retry) begin
          state_nxt = RD_ID;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: every register, including the data captures, is cleared by reset
    // so results after reset never show a stale compare from an earlier run.
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 16'd0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      state <= state_nxt;

      // Any state change clears the counter, which covers entry to both read
      // states (including a retry re-entering RD_ID).
      if (state_nxt != state)
        wait_cnt <= 16'd0;
      else if (in_read && avm_waitrequest)
        wait_cnt <= wait_cnt + 16'd1;

      if ((state == IDLE) && start) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end

      // A timed-out read never reaches these captures, so its ok flag stays 0
      // and its value register keeps the previous word.
      if ((state == RD_ID) && rd_done) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if ((state == RD_TS) && rd_done) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TS);
      end

      if (rd_timeout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qsys_sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qsys_sysid_check_ctrl
//
// Directed bench. Instance dut runs with default parameters against a small
// sysid slave model with programmable stall length; instance dut_to uses
// TIMEOUT_CYCLES=4 against a slave whose waitrequest is stuck high.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_qsys_sysid_check_ctrl;

  localparam logic [31:0] TS_WORD = 32'd1496327636;
`ifdef SYSID_CHECK_RETRY_EN
  localparam int BAD_LAT = 12;  // four passes of three cycles
`else
  localparam int BAD_LAT = 3;   // single pass
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  logic        start_t;
  logic        avm_address_t, avm_read_t;
  logic [31:0] avm_readdata_t;
  logic        avm_waitrequest_t;
  logic        busy_t, done_t, id_ok_t, ts_ok_t, timeout_err_t;
  logic [31:0] id_value_t, ts_value_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Slave model for dut: word select by address, stall_n waitrequest cycles per read.
  logic [31:0] slv_id = 32'd0;
  logic [31:0] slv_ts = TS_WORD;
  int          stall_n = 0;
  int          stall_cnt = 0;

  assign avm_readdata    = avm_address ? slv_ts : slv_id;
  assign avm_waitrequest = avm_read && (stall_cnt < stall_n);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
    else                               stall_cnt <= stall_cnt + 1;
  end

  always #5 clock = ~clock;

  qsys_sysid_check_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout_err     (timeout_err),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  qsys_sysid_check_ctrl #(.TIMEOUT_CYCLES(16'd4)) dut_to (
    .clock           (clock),
    .reset           (reset),
    .start           (start_t),
    .avm_address     (avm_address_t),
    .avm_read        (avm_read_t),
    .avm_readdata    (avm_readdata_t),
    .avm_waitrequest (avm_waitrequest_t),
    .busy            (busy_t),
    .done            (done_t),
    .id_ok           (id_ok_t),
    .ts_ok           (ts_ok_t),
    .timeout_err     (timeout_err_t),
    .id_value        (id_value_t),
    .ts_value        (ts_value_t)
  );

  // Pulse start for one cycle and return the cycle offset of done (-1 if none).
  task automatic run_seq(input int max_cyc, output int lat);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < max_cyc) begin
      @(negedge clock);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({busy, done, avm_read, avm_address, id_ok, ts_ok, timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {busy, done, avm_read, avm_address, id_ok, ts_ok, timeout_err});
    end
    checks++;
    if ({id_value, ts_value} !== 64'd0) begin
      errors++;
      $display("FAIL reset_values: got %h %h expected 0 0", id_value, ts_value);
    end
    checks++;
    if ({busy_t, avm_read_t, done_t, timeout_err_t} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl_to: got %b expected 0000",
               {busy_t, avm_read_t, done_t, timeout_err_t});
    end
    // A start coinciding with reset must be dropped.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || avm_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: busy=%b read=%b expected 0 0", busy, avm_read);
    end
  endtask

  task automatic test_nominal;
    while (cyc < 10) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (cyc !== 11 || {busy, avm_read, avm_address} !== 3'b110) begin
      errors++;
      $display("FAIL nom_rd_id: cyc=%0d bra=%b expected 11 110", cyc, {busy, avm_read, avm_address});
    end
    @(negedge clock);
    checks++;
    if ({busy, avm_read, avm_address, done} !== 4'b1110) begin
      errors++;
      $display("FAIL nom_rd_ts: got %b expected 1110", {busy, avm_read, avm_address, done});
    end
    @(negedge clock);
    checks++;
    if (cyc !== 13 || done !== 1'b1 || avm_read !== 1'b0) begin
      errors++;
      $display("FAIL nom_done: cyc=%0d done=%b read=%b expected 13 1 0", cyc, done, avm_read);
    end
    checks++;
    if ({id_ok, ts_ok, timeout_err} !== 3'b110 || id_value !== 32'd0 || ts_value !== TS_WORD) begin
      errors++;
      $display("FAIL nom_result: flags=%b id=%h ts=%h expected 110 0 %h",
               {id_ok, ts_ok, timeout_err}, id_value, ts_value, TS_WORD);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nom_idle: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_bad_ts;
    int lat;
    int busy_drop;
    slv_ts = 32'h1234_5678;
    busy_drop = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_drop++;
      @(negedge clock);
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== BAD_LAT) begin
      errors++;
      $display("FAIL bad_ts_latency: got %0d expected %0d", lat, BAD_LAT);
    end
    checks++;
    if (busy_drop !== 0) begin
      errors++;
      $display("FAIL bad_ts_busy: busy low %0d cycles expected 0", busy_drop);
    end
    checks++;
    if ({id_ok, ts_ok, timeout_err} !== 3'b100 || ts_value !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bad_ts_result: flags=%b ts=%h expected 100 12345678",
               {id_ok, ts_ok, timeout_err}, ts_value);
    end
    slv_ts = TS_WORD;
    @(negedge clock);
  endtask

  task automatic test_stall;
    int bad;
    bad = 0;
    stall_n = 5;
    start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done !== (k == 13)) bad++;
      if (k <= 12 && (avm_read !== 1'b1 || avm_address !== (k >= 7))) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_timing: %0d bad cycles expected 0", bad);
    end
    checks++;
    if ({id_ok, ts_ok, timeout_err} !== 3'b110) begin
      errors++;
      $display("FAIL stall_result: got %b expected 110", {id_ok, ts_ok, timeout_err});
    end
    stall_n = 0;
  endtask

  task automatic test_timeout;
    int pulses;
    pulses = 0;
    start_t = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      start_t = 1'b0;
      if (done_t === 1'b1) pulses++;
      if (k <= 4) begin
        checks++;
        if (avm_read_t !== 1'b1 || avm_address_t !== 1'b0) begin
          errors++;
          $display("FAIL to_stall_k%0d: read=%b addr=%b expected 1 0", k, avm_read_t, avm_address_t);
        end
      end
      if (k == 5) begin
        checks++;
        if ({avm_read_t, done_t, timeout_err_t, id_ok_t, ts_ok_t} !== 5'b01100) begin
          errors++;
          $display("FAIL to_abort: got %b expected 01100",
                   {avm_read_t, done_t, timeout_err_t, id_ok_t, ts_ok_t});
        end
      end
    end
    checks++;
    if (pulses !== 1 || id_value_t !== 32'd0 || ts_value_t !== 32'd0) begin
      errors++;
      $display("FAIL to_once: pulses=%0d id=%h ts=%h expected 1 0 0", pulses, id_value_t, ts_value_t);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int lat;
    slv_id = 32'h0BAD_0001;
    stall_n = 20;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (avm_address !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, avm_read, avm_address} !== 3'b111 || id_value !== 32'h0BAD_0001) begin
      errors++;
      $display("FAIL mid_pre: bra=%b id=%h expected 111 0bad0001",
               {busy, avm_read, avm_address}, id_value);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({busy, avm_read, avm_address, done, id_ok, ts_ok, timeout_err} !== 7'b0 ||
        {id_value, ts_value} !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: ctrl=%b id=%h ts=%h expected 0 0 0",
               {busy, avm_read, avm_address, done, id_ok, ts_ok, timeout_err}, id_value, ts_value);
    end
    slv_id = 32'd0;
    stall_n = 0;
    @(negedge clock);
    run_seq(20, lat);
    checks++;
    if (lat !== 3 || {id_ok, ts_ok, timeout_err} !== 3'b110) begin
      errors++;
      $display("FAIL mid_after: lat=%0d flags=%b expected 3 110", lat, {id_ok, ts_ok, timeout_err});
    end
    @(negedge clock);
  endtask

  task automatic test_start_busy;
    int pulses;
    int done_k;
    pulses = 0;
    done_k = -1;
    stall_n = 2;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        pulses++;
        done_k = k;
      end
      if (k == 9) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_ignored_fin: busy=%b expected 0", busy);
        end
      end
      start = (k == 2 || k == 7);
    end
    checks++;
    if (pulses !== 1 || done_k !== 7) begin
      errors++;
      $display("FAIL busy_single_done: pulses=%0d at=%0d expected 1 7", pulses, done_k);
    end
    stall_n = 0;
  endtask

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    start_t           = 1'b0;
    avm_readdata_t    = 32'hCAFE_F00D;
    avm_waitrequest_t = 1'b1;
    @(negedge clock);
    test_reset();
    test_nominal();
    test_bad_ts();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
